// File: rtl/mod_n_down_timer_pkg.sv
// Shared types for the loadable mod-N down-counter/timer.
package mod_n_down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mod_n_down_timer.sv
// Loadable mod-N down-counter: counts a reload value down to 0 and pulses tc at the wrap,
// in one-shot or auto-reload mode, with pause (HOLD) and abort (stop).
module mod_n_down_timer
  import mod_n_down_timer_pkg::*;
#(
  parameter int unsigned N     = 10,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(N - 1);

  state_t           state_q;
  logic [WIDTH-1:0] reload_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      count    <= ResetVal;
      reload_q <= ResetVal;
      tc       <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state_q)
        IDLE: begin
          // load_ready is implied by IDLE, so a valid alone completes the handshake
          if (load_valid) begin
            reload_q <= load_value;
            count    <= load_value;
          end
          if (start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            count   <= reload_q;
          end else if (pause) begin
            state_q <= HOLD;
          end else if (count != '0) begin
            count <= count - WIDTH'(1);
          end else begin
            tc    <= 1'b1;
            count <= reload_q;
            if (!auto_reload) begin
              state_q <= IDLE;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state_q <= IDLE;
            count   <= reload_q;
          end else if (!pause) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
          count   <= reload_q;
        end
      endcase
    end
  end

  always_comb begin
    load_ready = (state_q == IDLE);
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mod_n_down_timer.sv
// Directed bench for mod_n_down_timer (N=10, WIDTH=4) with hand-computed expectations.
module tb_mod_n_down_timer;

  logic       clk;
  logic       rstn;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_value;
  logic       start;
  logic       stop;
  logic       pause;
  logic       auto_reload;
  logic [3:0] count;
  logic       tc;
  logic       busy;

  int n_vec;
  int n_err;

  mod_n_down_timer #(
    .N    (10),
    .WIDTH(4)
  ) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int c, input int t, input int b);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".tc"}, int'(tc), t);
    check({tag, ".busy"}, int'(busy), b);
  endtask

  // Auto-reload of 3: count and tc after each edge following start
  int ar_cnt[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
  int ar_tc[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
  // One-shot of 5: count, tc, busy after each edge following start
  int os_cnt[7]  = '{4, 3, 2, 1, 0, 5, 5};
  int os_tc[7]   = '{0, 0, 0, 0, 0, 1, 0};
  int os_busy[7] = '{1, 1, 1, 1, 1, 0, 0};
  // Pause with reload 4, starting just after a tc (count=4)
  int ps_pause[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
  int ps_cnt[8]   = '{3, 2, 2, 2, 2, 1, 0, 4};
  int ps_tc[8]    = '{0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rstn        = 1'b0;
    load_valid  = 1'b0;
    load_value  = '0;
    start       = 1'b0;
    stop        = 1'b0;
    pause       = 1'b0;
    auto_reload = 1'b0;

    step();
    step();
    check_state("reset", 9, 0, 0);
    check("reset.load_ready", int'(load_ready), 1);
    rstn = 1'b1;

    // Auto-reload, V=3
    auto_reload = 1'b1;
    load_valid  = 1'b1;
    load_value  = 4'd3;
    step();
    check_state("ar.load", 3, 0, 0);
    load_valid = 1'b0;
    start      = 1'b1;
    step();
    check_state("ar.start", 3, 0, 1);
    check("ar.load_ready", int'(load_ready), 0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_state($sformatf("ar[%0d]", i), ar_cnt[i], ar_tc[i], 1);
    end

    // Load offered while busy must be ignored; then abort at count=1
    load_valid = 1'b1;
    load_value = 4'd9;
    check("busy.load_ready", int'(load_ready), 0);
    step();
    check_state("busy.load", 2, 0, 1);
    load_valid = 1'b0;
    step();
    check_state("abort.pre", 1, 0, 1);
    stop = 1'b1;
    step();
    check_state("abort", 3, 0, 0);
    stop = 1'b0;
    step();
    check_state("abort.after", 3, 0, 0);
    check("abort.load_ready", int'(load_ready), 1);

    // One-shot, V=5
    auto_reload = 1'b0;
    load_valid  = 1'b1;
    load_value  = 4'd5;
    step();
    load_valid = 1'b0;
    start      = 1'b1;
    step();
    check_state("os.start", 5, 0, 1);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check_state($sformatf("os[%0d]", i), os_cnt[i], os_tc[i], os_busy[i]);
    end

    // Pause in auto-reload, V=4: run to first tc, then a paused 8-cycle period
    auto_reload = 1'b1;
    load_valid  = 1'b1;
    load_value  = 4'd4;
    start       = 1'b1;
    step();
    check_state("ps.start", 4, 0, 1);
    load_valid = 1'b0;
    start      = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_state("ps.first_tc", 4, 1, 1);
    for (int i = 0; i < 8; i++) begin
      pause = ps_pause[i][0];
      step();
      check_state($sformatf("ps[%0d]", i), ps_cnt[i], ps_tc[i], 1);
    end
    stop = 1'b1;
    step();
    check_state("ps.stop", 4, 0, 0);
    stop = 1'b0;

    // Simultaneous load and start
    load_valid = 1'b1;
    load_value = 4'd7;
    start      = 1'b1;
    step();
    check_state("ls.start", 7, 0, 1);
    load_valid = 1'b0;
    start      = 1'b0;
    step();
    check_state("ls.dec", 6, 0, 1);

    // Reset mid-count restores N-1 in both count and reload
    rstn = 1'b0;
    step();
    check_state("rst_mid", 9, 0, 0);
    rstn  = 1'b1;
    start = 1'b1;
    step();
    check_state("rst_mid.start", 9, 0, 1);
    start = 1'b0;
    stop  = 1'b1;
    step();
    check_state("rst_mid.stop", 9, 0, 0);
    stop = 1'b0;

    // Load 0 in auto-reload: tc every cycle in RUN
    load_valid = 1'b1;
    load_value = 4'd0;
    start      = 1'b1;
    step();
    check_state("z.start", 0, 0, 1);
    load_valid = 1'b0;
    start      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("z[%0d]", i), 0, 1, 1);
    end
    stop = 1'b1;
    step();
    check_state("z.stop", 0, 0, 0);
    stop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
